alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, ALU result width.
REQ-002 SHALL have parameter RD_W, default 4, destination-register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  ALU result presented this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  DATA_W  signed ALU result.
REQ-008 in_z, in_n, in_v, in_c  input  1 each  ALU flags for in_result.
REQ-009 in_op  input  4  ALU operation code (alu_pkg encoding).
REQ-010 in_rd  input  RD_W  destination register index.
REQ-011 in_set_flags  input  1  commit flags to status register on acceptance.
REQ-012 wb_valid  output  1  writeback entry available.
REQ-013 wb_ready  input  1  register file consumes entry this cycle.
REQ-014 wb_rd  output  RD_W; wb_data  output  DATA_W  head entry fields.
REQ-015 nzcv  output  4  status register {N,Z,C,V}.
REQ-016 div0_sticky  output  1  a DIV or MOD with in_result==0 and in_z==1 retired since reset/clear.
REQ-017 div0_clr  input  1  clears div0_sticky.
REQ-018 cond  input  4; cond_true  output  1  condition evaluation against nzcv.

Function
REQ-019 SHALL buffer up to 2 entries in FIFO order; states EMPTY, ONE, FULL.
REQ-020 Accept = in_valid && in_ready; pop = wb_valid && wb_ready.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL (registered-state only, no comb path from wb_ready).
REQ-022 Transitions: EMPTY->ONE on accept; ONE->FULL on accept w/o pop; ONE->EMPTY on pop w/o accept; ONE->ONE on both; FULL->ONE on pop.
REQ-023 Entry accepted at edge N SHALL be visible on wb_valid/wb_rd/wb_data after edge N (1-cycle latency when empty).
REQ-024 wb_rd/wb_data SHALL hold stable while wb_valid && !wb_ready.
REQ-025 nzcv SHALL update at the accepting edge iff in_set_flags=1; otherwise retain value.
REQ-026 div0_sticky SHALL set at the accepting edge for in_op DIV/MOD with in_result==0 && in_z==1; div0_clr in same cycle loses to set.
REQ-027 cond_true combinational from nzcv: 0 EQ Z; 1 NE !Z; 2 LT N!=V; 3 GE N==V; 4 GT !Z&&N==V; 5 LE Z||N!=V; 6 CS C; 7 CC !C; 8 MI N; 9 PL !N; 14 AL 1; others 0.
REQ-028 in_valid with in_ready=0 SHALL be ignored with no state change.

Reset
REQ-029 At rst: state EMPTY, wb_valid=0, in_ready=1 after edge, wb_rd=0, wb_data=0, nzcv=0, div0_sticky=0.
REQ-030 rst mid-operation SHALL discard all buffered entries; rst overrides accept and pop in same cycle.

Configuration
REQ-031 Macro ALU_WB_COND_EVAL_EN: defined -> REQ-027 logic present; undefined -> cond_true tied 0, cond ignored, nzcv still maintained.

Structure
REQ-032 alu_pkg SHALL hold op enum (ADD 0000, SUB 0001, MUL 0010, DIV 0011, MOD 0100), cond enum, and flags struct {n,z,c,v}.
REQ-033 The 2-entry buffer SHALL be sub-module wb_fifo2; flags/cond logic stays in alu_wb_stage.

Verification
REQ-034 ADD 5+10, rd=3, set_flags=1, wb_ready=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=15, nzcv=0000.
REQ-035 wb_ready=0, three back-to-back accepts (1,2,3) -> in_ready=0 after two; release -> data 1 then 2, third retried and delivered as 3.
REQ-036 SUB 5-10 set_flags=1 (n=1) then cond=2 LT -> cond_true=1; cond=3 GE -> 0; cond=14 -> 1.
REQ-037 DIV 8/0 (result 0, z=1) -> div0_sticky=1 next cycle; div0_clr -> 0; set_flags=0 leaves nzcv unchanged.
REQ-038 FULL buffer then rst=1 one cycle -> wb_valid=0, in_ready=1, nzcv=0, div0_sticky=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings for the writeback stage.
// Holds the operation and condition enums, the flags struct and the
// condition evaluator used by alu_wb_stage when ALU_WB_COND_EVAL_EN is defined.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_MUL = 4'b0010,
      OP_DIV = 4'b0011,
      OP_MOD = 4'b0100
   } op_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_LT = 4'd2,
      COND_GE = 4'd3,
      COND_GT = 4'd4,
      COND_LE = 4'd5,
      COND_CS = 4'd6,
      COND_CC = 4'd7,
      COND_MI = 4'd8,
      COND_PL = 4'd9,
      COND_AL = 4'd14
   } cond_e;

   // Packed in {N,Z,C,V} order so it maps directly onto the nzcv port.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Evaluate a condition code against the status flags; unlisted codes are false.
   function automatic logic cond_eval(input logic [3:0] cond, input flags_t f);
      logic r;
      r = 1'b0;
      case (cond)
         COND_EQ: r = f.z;
         COND_NE: r = !f.z;
         COND_LT: r = (f.n != f.v);
         COND_GE: r = (f.n == f.v);
         COND_GT: r = !f.z && (f.n == f.v);
         COND_LE: r = f.z || (f.n != f.v);
         COND_CS: r = f.c;
         COND_CC: r = !f.c;
         COND_MI: r = f.n;
         COND_PL: r = !f.n;
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: two-entry FIFO with registered ready/valid.
// push_ready depends only on registered state, so there is no
// combinational path from pop_ready back to push_ready.
module wb_fifo2 #(
   parameter int W = 36
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e       state;
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic         push;
   logic         pop;

   assign push     = push_valid && push_ready;
   assign pop      = pop_valid && pop_ready;
   assign pop_data = head;

   // Occupancy FSM with storage and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         // NOTE: the entry registers are reset as well, because the head entry
         // is visible on the outputs and must read as zero after reset.
         head       <= '0;
         tail       <= '0;
         push_ready <= 1'b1;
         pop_valid  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update in this
         // block reading pre-edge values, whatever order they are written in.
         case (state)
            EMPTY: begin
               if (push) begin
                  head      <= push_data;
                  pop_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head <= push_data;
               end else if (push) begin
                  tail       <= push_data;
                  push_ready <= 1'b0;
                  state      <= FULL;
               end else if (pop) begin
                  pop_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head       <= tail;
                  push_ready <= 1'b1;
                  state      <= ONE;
               end
            end
            default: begin
               state      <= EMPTY;
               push_ready <= 1'b1;
               pop_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback stage with a 2-entry result buffer,
// NZCV status register and sticky divide-by-zero flag.
// Optional feature macro: ALU_WB_COND_EVAL_EN enables condition evaluation
// on cond_true; without it cond_true is tied low and cond is ignored.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_result,
   input  logic                     in_z,
   input  logic                     in_n,
   input  logic                     in_v,
   input  logic                     in_c,
   input  logic [3:0]               in_op,
   input  logic [RD_W-1:0]          in_rd,
   input  logic                     in_set_flags,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [RD_W-1:0]          wb_rd,
   output logic [DATA_W-1:0]        wb_data,
   output logic [3:0]               nzcv,
   output logic                     div0_sticky,
   input  logic                     div0_clr,
   input  logic [3:0]               cond,
   output logic                     cond_true
);

   localparam int ENTRY_W = RD_W + DATA_W;

   logic [ENTRY_W-1:0] head_entry;
   logic               accept;
   logic               div0_hit;
   op_e                op;
   flags_t             flags_q;

   wb_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  ({in_rd, in_result}),
      .pop_valid  (wb_valid),
      .pop_ready  (wb_ready),
      .pop_data   (head_entry)
   );

   assign {wb_rd, wb_data} = head_entry;

   assign op       = op_e'(in_op);
   assign accept   = in_valid && in_ready;
   assign div0_hit = accept && (op == OP_DIV || op == OP_MOD)
                     && (in_result == '0) && in_z;

   // Status register and sticky divide-by-zero flag; a new hit beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q     <= '0;
         div0_sticky <= 1'b0;
      end else begin
         if (accept && in_set_flags) begin
            flags_q <= '{n: in_n, z: in_z, c: in_c, v: in_v};
         end
         if (div0_hit) begin
            div0_sticky <= 1'b1;
         end else if (div0_clr) begin
            div0_sticky <= 1'b0;
         end
      end
   end

   assign nzcv = flags_q;

   // Condition evaluation against the committed status flags.
   always_comb begin
      // NOTE: assign a default before any conditional logic so no path
      // leaves cond_true unassigned and a latch cannot be inferred.
      cond_true = 1'b0;
`ifdef ALU_WB_COND_EVAL_EN
      cond_true = cond_eval(cond, flags_q);
`endif
   end

`ifndef ALU_WB_COND_EVAL_EN
   logic cond_unused;
   assign cond_unused = ^cond;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: scoreboard bench for alu_wb_stage with directed vectors.
module tb_alu_wb_stage;
   import alu_pkg::*;

`ifdef ALU_WB_COND_EVAL_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_result;
   logic               in_z, in_n, in_v, in_c;
   logic [3:0]         in_op;
   logic [3:0]         in_rd;
   logic               in_set_flags;
   logic               wb_valid;
   logic               wb_ready;
   logic [3:0]         wb_rd;
   logic [31:0]        wb_data;
   logic [3:0]         nzcv;
   logic               div0_sticky;
   logic               div0_clr;
   logic [3:0]         cond;
   logic               cond_true;

   alu_wb_stage #(.DATA_W(32), .RD_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_z         (in_z),
      .in_n         (in_n),
      .in_v         (in_v),
      .in_c         (in_c),
      .in_op        (in_op),
      .in_rd        (in_rd),
      .in_set_flags (in_set_flags),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .nzcv         (nzcv),
      .div0_sticky  (div0_sticky),
      .div0_clr     (div0_clr),
      .cond         (cond),
      .cond_true    (cond_true)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t     sb[$];
   int       checks   = 0;
   int       failures = 0;
   int       occ      = 0;
   bit       mon_en   = 1'b0;
   bit       last_acc = 1'b0;
   logic [3:0] exp_nzcv = 4'b0000;
   logic       exp_div0 = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Independent condition model for the continuous cond_true check.
   function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return n ^ v;
         4'd3:    return !(n ^ v);
         4'd4:    return !z && !(n ^ v);
         4'd5:    return z || (n ^ v);
         4'd6:    return cf;
         4'd7:    return !cf;
         4'd8:    return n;
         4'd9:    return !n;
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Monitor/scoreboard: compare DUT outputs, pop on handshake, then
   // advance the occupancy and flag model for the coming edge.
   always @(negedge clk) begin
      bit acc, pop;
      exp_t e;
      if (mon_en) begin
         check("in_ready", in_ready, occ < 2);
         check("wb_valid", wb_valid, occ > 0);
         check("nzcv", nzcv, exp_nzcv);
         check("div0_sticky", div0_sticky, exp_div0);
         check("cond_true", cond_true, COND_EN ? cond_model(cond, exp_nzcv) : 1'b0);
         if (wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", 1'b0, 1'b1);
            end else begin
               e = sb[0];
               check("wb_rd", wb_rd, e.rd);
               check("wb_data", wb_data, e.data);
            end
         end
         pop = (occ > 0) && wb_ready;
         acc = in_valid && (occ < 2);
         if (rst) begin
            occ      = 0;
            sb.delete();
            exp_nzcv = 4'b0000;
            exp_div0 = 1'b0;
            last_acc = 1'b0;
         end else begin
            if (pop && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
               sb.push_back('{rd: in_rd, data: in_result});
               if (in_set_flags) exp_nzcv = {in_n, in_z, in_c, in_v};
            end
            if (acc && (in_op == 4'b0011 || in_op == 4'b0100) && in_result == 0 && in_z)
               exp_div0 = 1'b1;
            else if (div0_clr)
               exp_div0 = 1'b0;
            occ      = occ + int'(acc) - int'(pop);
            last_acc = acc;
         end
      end
   end

   // Present one ALU result and hold it until accepted (bounded).
   task automatic send(input logic [3:0] op, input logic signed [31:0] res,
                       input logic [3:0] f_nzcv, input logic [3:0] rd, input logic set_f);
      bit got = 1'b0;
      in_valid     = 1'b1;
      in_op        = op;
      in_result    = res;
      {in_n, in_z, in_c, in_v} = f_nzcv;
      in_rd        = rd;
      in_set_flags = set_f;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         #1;
         if (last_acc) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      in_set_flags = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((occ != 0 || in_valid) && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", occ, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_result = '0;
      {in_n, in_z, in_c, in_v} = 4'b0000;
      in_op = 4'b0000; in_rd = '0; in_set_flags = 1'b0;
      wb_ready = 1'b0; div0_clr = 1'b0; cond = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_rd", wb_rd, 4'd0);
      check("rst_nzcv", nzcv, 4'b0000);
      check("rst_div0", div0_sticky, 1'b0);
      mon_en = 1'b1;

      // ADD 5+10 -> rd3 = 15, flags all clear, visible one cycle later.
      wb_ready = 1'b1;
      send(4'b0000, 32'sd15, 4'b0000, 4'd3, 1'b1);
      check("add_wb_valid", wb_valid, 1'b1);
      check("add_wb_rd", wb_rd, 4'd3);
      check("add_wb_data", wb_data, 32'd15);
      check("add_nzcv", nzcv, 4'b0000);
      drain();

      // Back-pressure: two accepts fill the buffer, third waits.
      wb_ready = 1'b0;
      send(4'b0000, 32'sd1, 4'b0000, 4'd1, 1'b0);
      send(4'b0000, 32'sd2, 4'b0000, 4'd2, 1'b0);
      check("full_in_ready", in_ready, 1'b0);
      check("full_head_data", wb_data, 32'd1);
      fork
         send(4'b0000, 32'sd3, 4'b0000, 4'd3, 1'b0);
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold_data", wb_data, 32'd1);
      wb_ready = 1'b1;
      drain();

      // SUB 5-10 = -5, N set; conditions LT/GE/AL.
      send(4'b0001, -32'sd5, 4'b1000, 4'd4, 1'b1);
      check("sub_nzcv", nzcv, 4'b1000);
      cond = 4'd2; #1;
      check("cond_lt", cond_true, COND_EN ? 1'b1 : 1'b0);
      cond = 4'd3; #1;
      check("cond_ge", cond_true, 1'b0);
      cond = 4'd14; #1;
      check("cond_al", cond_true, COND_EN ? 1'b1 : 1'b0);
      cond = 4'd11; #1;
      check("cond_rsvd", cond_true, 1'b0);
      drain();

      // DIV 8/0 sets sticky without touching flags; clear; set beats clear.
      send(4'b0011, 32'sd0, 4'b0100, 4'd5, 1'b0);
      check("div0_set", div0_sticky, 1'b1);
      check("div0_nzcv_kept", nzcv, 4'b1000);
      div0_clr = 1'b1;
      @(posedge clk); #1;
      div0_clr = 1'b0;
      check("div0_clr", div0_sticky, 1'b0);
      send(4'b0010, 32'sd0, 4'b0100, 4'd6, 1'b0);
      check("mul_zero_no_div0", div0_sticky, 1'b0);
      div0_clr = 1'b1;
      send(4'b0100, 32'sd0, 4'b0100, 4'd7, 1'b0);
      div0_clr = 1'b0;
      check("div0_set_beats_clr", div0_sticky, 1'b1);
      drain();

      // Fill the buffer, then reset with accept and pop both requested.
      wb_ready = 1'b0;
      send(4'b0000, 32'sd21, 4'b0010, 4'd8, 1'b1);
      send(4'b0000, 32'sd22, 4'b0001, 4'd9, 1'b1);
      check("pre_rst_in_ready", in_ready, 1'b0);
      rst = 1'b1; wb_ready = 1'b1; in_valid = 1'b1;
      in_result = 32'sd99; in_rd = 4'd10; in_set_flags = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; in_set_flags = 1'b0; wb_ready = 1'b0;
      check("mid_rst_wb_valid", wb_valid, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_nzcv", nzcv, 4'b0000);
      check("mid_rst_div0", div0_sticky, 1'b0);
      check("mid_rst_wb_data", wb_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
